// File: rtl/sfifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// threshold flags, occupancy count and overflow/underflow pulses.
module sfifo_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AFULL_TH   = 500,
  parameter int unsigned AEMPTY_TH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] fifo_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  wr_full,
  output logic                  rd_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  wr_acc, rd_acc, load;
  logic [CW-1:0]         mem_cnt;

  // Next-state: acceptance, count, output-register load and flags from next count.
  always_comb begin
    wr_acc      = wr_en & ~full_q;
    rd_acc      = rd_en & ~empty_q;
    mem_cnt     = cnt_q - CW'(out_valid_q);
    load        = 1'b0;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q;

    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // In FWFT the output register is refilled from memory whenever it is free or popped;
    // a word written on this edge is not yet in memory, hence the one-edge fall-through delay.
    if (FWFT != 0) begin
      load        = (mem_cnt != '0) & (~out_valid_q | rd_acc);
      out_valid_d = load | (out_valid_q & ~rd_acc);
    end else begin
      load        = rd_acc;
    end

    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = load   ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    dout_d   = load   ? mem[rd_ptr_q] : dout_q;

    full_d   = (cnt_d == DEPTH_C);
    empty_d  = (FWFT != 0) ? ~out_valid_d : (cnt_d == '0);
    afull_d  = (cnt_d >= AFULL_C);
    aempty_d = (cnt_d <= AEMPTY_C);
    ovf_d    = wr_en & full_q;
    unf_d    = rd_en & empty_q;
  end

  // Storage array: no reset so it maps onto simple dual-port block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr_q] <= fifo_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign fifo_out     = dout_q;
  assign wr_full      = full_q;
  assign rd_empty     = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign data_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: doc/sfifo_param.md
Name: sfifo_param

Overview:
- Single-clock, parametrised synchronous FIFO. It is the successor to the team's dual-clock gray-pointer FIFO, used wherever producer and consumer share one clock domain.
- Adds the following over the earlier block:
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - programmable almost-full and almost-empty thresholds;
  - an occupancy count;
  - overflow and underflow error pulses.
- Sits between stream producers and consumers (ADC capture, UART/packet buffers) inside the FPGA logic tree.

Parameters:
- DATA_WIDTH, 16: word width in bits.
- ADDR_WIDTH, 9: address bits; depth DEPTH = 2^ADDR_WIDTH (512).
- FWFT, 0: read mode. 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.
- AFULL_TH, 500: almost_full asserts when data_cnt >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 4: almost_empty asserts when data_cnt <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write request.
- fifo_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (standard mode) / pop request (FWFT mode).
- fifo_out  out  DATA_WIDTH  read data.
- wr_full  out  1  FIFO full; writes are ignored.
- rd_empty  out  1  no readable word; reads are ignored.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- data_cnt  out  ADDR_WIDTH+1  words held (0..DEPTH). In FWFT mode this includes the word presented on fifo_out.
- overflow  out  1  one-cycle pulse: write requested while full.
- underflow  out  1  one-cycle pulse: read requested while empty.

Behaviour:
- One synchronous active-high reset, sampled on the clk rising edge.
- Reset values:
  - fifo_out = 0, data_cnt = 0, wr_full = 0, almost_full = 0, overflow = 0, underflow = 0;
  - rd_empty = 1, almost_empty = 1;
  - write and read pointers = 0.
- Memory contents are not cleared on reset. Reset asserted mid-operation discards all stored data on that edge.
- Write acceptance: wr_acc = wr_en & ~wr_full. The accepted word goes to mem[wr_ptr]; wr_ptr increments modulo DEPTH, wrapping to 0 after DEPTH-1.
- Read acceptance: rd_acc = rd_en & ~rd_empty. rd_ptr increments modulo DEPTH.
- All flags and data_cnt are registered. They are computed from the next-state count, so they are exact (no lag) in the cycle after the edge that changed occupancy.
- Count update:
  - wr_acc only: +1;
  - rd_acc only: -1;
  - both or neither: unchanged.
- Standard mode (FWFT=0):
  - wr_full = (data_cnt == DEPTH); rd_empty = (data_cnt == 0).
  - On rd_acc at edge N, fifo_out takes mem[rd_ptr], valid after edge N.
  - fifo_out holds its value when there is no rd_acc.
  - A write at edge N into an empty FIFO makes rd_empty 0 after edge N; the earliest read accept is at edge N+1.
- FWFT mode (FWFT=1):
  - An output register holds the head word. rd_empty = 0 exactly when the output register is valid.
  - A write into an empty FIFO at edge N gives fifo_out = that word and rd_empty = 0 after edge N+1.
  - rd_acc pops the head. The next word, if present in memory, is loaded into the output register on the same edge, so back-to-back pops run at 1 word/cycle.
  - If memory is empty at the pop, rd_empty goes to 1.
  - wr_full = (data_cnt == DEPTH).
- Simultaneous events:
  - Write and read in the same cycle, neither flag set: both accepted, data_cnt unchanged.
  - When full: the read is accepted, the write is rejected, and overflow pulses.
  - When empty: the write is accepted, the read is rejected, and underflow pulses. In FWFT mode the word appears per the FWFT latency above.
- overflow = registered (wr_en & wr_full); underflow = registered (rd_en & rd_empty). Each is high for exactly one cycle per offending request cycle.
- A rejected request changes no pointer, memory location, or count.
- Threshold flags: almost_full = (data_cnt >= AFULL_TH); almost_empty = (data_cnt <= AEMPTY_TH).
- Memory is inferred as simple dual-port block RAM (one write port, one read port). No reads-during-write bypass is needed beyond FWFT empty handling.

Test Plan:
1. Reset then idle → rd_empty=1, almost_empty=1, wr_full=0, data_cnt=0, fifo_out=0, no error pulses.
2. Standard mode, DATA_WIDTH=16, ADDR_WIDTH=3:
   - write 0x0001..0x0008 → wr_full=1, data_cnt=8, almost_full=1 with AFULL_TH=6;
   - a 9th write → overflow pulse for 1 cycle, data_cnt stays 8;
   - read 8 words → fifo_out 0x0001..0x0008, each one cycle after its accept, then rd_empty=1.
3. FWFT=1:
   - write 0xABCD into an empty FIFO → fifo_out=0xABCD and rd_empty=0 one edge later, with no rd_en;
   - rd_en pops → rd_empty=1, data_cnt=0.
4. Pointer wrap (ADDR_WIDTH=3): write 6, read 6, write 8, read 8 → data returned in order across wrap, counts correct throughout.
5. Simultaneous write and read:
   - at data_cnt=4, 10 cycles of wr_en=rd_en=1 → data_cnt stays 4, ordering preserved;
   - at full → read accepted, write rejected, overflow=1;
   - at empty → underflow=1, data_cnt=1.
6. Reset asserted mid-burst at data_cnt=5 → next cycle data_cnt=0, rd_empty=1; a subsequent write/read returns only the new data.
